// File: rtl/ctrl_pkg.sv
// Purpose: op codes and sequencer state encoding shared with the training controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ctrl_pkg;

    localparam int OP_NOP       = 0;
    localparam int OP_SET_LAYER = 1;
    localparam int OP_SET_COST  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/code_rom.sv
// Purpose: PROG_DEPTH x OP_SIZE program store, synchronous write, combinational read.
// Latency: write visible on the read port the cycle after the write strobe.
// Backpressure: none; the caller gates the write strobe.
// Ports: clk; we/wr_addr/wr_dat write port; rd_addr/rd_dat asynchronous read port.
// Contents are deliberately not reset so a loaded program survives a controller reset.
module code_rom #(
    parameter int OP_SIZE = 4,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [OP_SIZE-1:0] wr_dat,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [OP_SIZE-1:0] rd_dat
);

    logic [OP_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/code_sequencer.sv
// Purpose: steps the training controller through a stored op program for EPOCHS passes.
// Latency: feedback sampled in cycle N shows up on op/code_index/code_count in cycle N+1.
// Backpressure: feedback only acts while enable=1; with SEQ_STALL_EN defined, stall=1 drops enable and freezes everything.
// Ports: clk, rst (async, active high); start; prog_we/prog_addr/prog_op program load
//   (ignored in RUN); count_reset/code_reset/code_active controller feedback;
//   op/code_index/code_count/enable to the controller; busy/done/epoch_left status.
// Build option: SEQ_STALL_EN adds the stall input.
module code_sequencer
    import ctrl_pkg::*;
#(
    parameter int OP_SIZE    = 4,
    parameter int PROG_DEPTH = 8,
    parameter int EPOCHS     = 3,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [OP_SIZE-1:0] prog_op,
    input  logic               count_reset,
    input  logic               code_reset,
    input  logic               code_active,
`ifdef SEQ_STALL_EN
    input  logic               stall,
`endif
    output logic [OP_SIZE-1:0] op,
    output logic [31:0]        code_index,
    output logic [31:0]        code_count,
    output logic               enable,
    output logic               busy,
    output logic               done,
    output logic [31:0]        epoch_left
);

    localparam logic [31:0] LAST_LINE   = 32'(PROG_DEPTH - 1);
    localparam logic [31:0] EPOCHS_INIT = 32'(EPOCHS);

    seq_state_t  state, state_nxt;
    logic [31:0] index_nxt, count_nxt, epoch_nxt;
    logic        end_epoch;
    logic [OP_SIZE-1:0] rom_dat;

    // Program changes are locked out while a run is in flight.
    code_rom #(
        .OP_SIZE (OP_SIZE),
        .DEPTH   (PROG_DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_rom (
        .clk     (clk),
        .we      (prog_we && (state != RUN)),
        .wr_addr (prog_addr),
        .wr_dat  (prog_op),
        .rd_addr (code_index[ADDR_W-1:0]),
        .rd_dat  (rom_dat)
    );

`ifdef SEQ_STALL_EN
    assign enable = (state == RUN) && !stall;
`else
    assign enable = (state == RUN);
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign op   = (state == RUN) ? rom_dat : OP_SIZE'(OP_NOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            code_index <= '0;
            code_count <= '0;
            epoch_left <= EPOCHS_INIT;
        end else begin
            state      <= state_nxt;
            code_index <= index_nxt;
            code_count <= count_nxt;
            epoch_left <= epoch_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        index_nxt = code_index;
        count_nxt = code_count;
        epoch_nxt = epoch_left;
        end_epoch = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    index_nxt = '0;
                    count_nxt = '0;
                    epoch_nxt = EPOCHS_INIT;
                end
            end
            RUN: begin
                if (enable) begin
                    if (code_reset) begin
                        end_epoch = 1'b1;
                    end else if (count_reset && code_active) begin
                        // Advancing past the last line is an implicit end of epoch.
                        if (code_index == LAST_LINE) begin
                            end_epoch = 1'b1;
                        end else begin
                            index_nxt = code_index + 32'd1;
                            count_nxt = '0;
                        end
                    end else if (count_reset) begin
                        count_nxt = '0;
                    end else if (code_count != 32'hFFFF_FFFF) begin
                        count_nxt = code_count + 32'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (end_epoch) begin
            index_nxt = '0;
            count_nxt = '0;
            epoch_nxt = epoch_left - 32'd1;
            if (epoch_left == 32'd1) begin
                state_nxt = DONE;
            end
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
// Purpose: directed self-checking bench for code_sequencer (PROG_DEPTH=8, EPOCHS=3).
// Latency: inputs change and outputs are sampled 1ns after each rising edge.
// Backpressure: stall scenario only present when SEQ_STALL_EN is defined.
module tb_code_sequencer;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = '0;
    logic [3:0]  prog_op = '0;
    logic        count_reset = 1'b0;
    logic        code_reset = 1'b0;
    logic        code_active = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  op;
    logic [31:0] code_index, code_count, epoch_left;
    logic        enable, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    code_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_op     (prog_op),
        .count_reset (count_reset),
        .code_reset  (code_reset),
        .code_active (code_active),
`ifdef SEQ_STALL_EN
        .stall       (stall),
`endif
        .op          (op),
        .code_index  (code_index),
        .code_count  (code_count),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .epoch_left  (epoch_left)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step_adv;
        count_reset = 1'b1;
        code_active = 1'b1;
        tick();
        count_reset = 1'b0;
        code_active = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++; if (code_index !== 32'd0) begin errors++; $display("FAIL rst_index: got %0d want 0", code_index); end
        checks++; if (code_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", code_count); end
        checks++; if (epoch_left !== 32'd3) begin errors++; $display("FAIL rst_epoch: got %0d want 3", epoch_left); end
        checks++; if ({busy, done, enable} !== 3'b000) begin errors++; $display("FAIL rst_flags: got busy/done/enable=%b want 000", {busy, done, enable}); end
        checks++; if (op !== 4'd0) begin errors++; $display("FAIL rst_op: got %0d want 0", op); end
        rst = 1'b0;
        // Feedback outside RUN must not move the counters.
        count_reset = 1'b1; code_active = 1'b1; code_reset = 1'b1;
        tick();
        count_reset = 1'b0; code_active = 1'b0; code_reset = 1'b0;
        checks++; if ({code_index, epoch_left} !== {32'd0, 32'd3}) begin errors++; $display("FAIL idle_feedback: got index=%0d epoch=%0d want 0/3", code_index, epoch_left); end
    endtask

    task automatic load_program;
        for (int i = 0; i < 8; i++) begin
            prog_we   = 1'b1;
            prog_addr = 3'(i);
            prog_op   = (i == 1) ? 4'(OP_SET_COST) : 4'(OP_NOP);
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic test_run;
        // Write line 0 and start in the same cycle: run must see the new op.
        prog_we = 1'b1; prog_addr = 3'd0; prog_op = 4'(OP_SET_LAYER); start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        checks++; if ({busy, enable} !== 2'b11) begin errors++; $display("FAIL run_busy: got busy/enable=%b want 11", {busy, enable}); end
        checks++; if (op !== 4'd1) begin errors++; $display("FAIL run_op_new: got %0d want 1", op); end
        checks++; if (code_count !== 32'd0) begin errors++; $display("FAIL run_count0: got %0d want 0", code_count); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (code_count !== 32'(k)) begin errors++; $display("FAIL run_count%0d: got %0d want %0d", k, code_count, k); end
            checks++; if ({code_index, 28'd0, op} !== {32'd0, 32'd1}) begin errors++; $display("FAIL run_hold%0d: got index=%0d op=%0d want 0/1", k, code_index, op); end
        end
        step_adv();
        checks++; if ({code_index, code_count} !== {32'd1, 32'd0}) begin errors++; $display("FAIL adv_1: got index=%0d count=%0d want 1/0", code_index, code_count); end
        checks++; if (op !== 4'd2) begin errors++; $display("FAIL adv_op: got %0d want 2", op); end
        // count_reset alone clears count but holds the line.
        tick();
        count_reset = 1'b1;
        tick();
        count_reset = 1'b0;
        checks++; if ({code_index, code_count} !== {32'd1, 32'd0}) begin errors++; $display("FAIL count_reset_only: got index=%0d count=%0d want 1/0", code_index, code_count); end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 6; k++) step_adv();
        checks++; if ({code_index, epoch_left} !== {32'd7, 32'd3}) begin errors++; $display("FAIL wrap_pre: got index=%0d epoch=%0d want 7/3", code_index, epoch_left); end
        step_adv();
        checks++; if ({code_index, epoch_left} !== {32'd0, 32'd2}) begin errors++; $display("FAIL wrap: got index=%0d epoch=%0d want 0/2", code_index, epoch_left); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy: got %b want 1", busy); end
    endtask

    task automatic test_priority;
        step_adv();
        step_adv();
        tick();
        checks++; if ({code_index, code_count} !== {32'd2, 32'd1}) begin errors++; $display("FAIL prio_pre: got index=%0d count=%0d want 2/1", code_index, code_count); end
        code_reset = 1'b1; count_reset = 1'b1; code_active = 1'b1;
        tick();
        code_reset = 1'b0; count_reset = 1'b0; code_active = 1'b0;
        checks++; if ({code_index, code_count, epoch_left} !== {32'd0, 32'd0, 32'd1}) begin errors++; $display("FAIL prio: got index=%0d count=%0d epoch=%0d want 0/0/1", code_index, code_count, epoch_left); end
    endtask

    task automatic test_mid_reset;
        step_adv(); step_adv(); step_adv();
        for (int k = 0; k < 5; k++) tick();
        checks++; if ({code_index, code_count} !== {32'd3, 32'd5}) begin errors++; $display("FAIL midrst_pre: got index=%0d count=%0d want 3/5", code_index, code_count); end
        rst = 1'b1;
        tick();
        checks++; if ({code_index, code_count, epoch_left} !== {32'd0, 32'd0, 32'd3}) begin errors++; $display("FAIL midrst: got index=%0d count=%0d epoch=%0d want 0/0/3", code_index, code_count, epoch_left); end
        checks++; if ({busy, enable, op} !== 6'd0) begin errors++; $display("FAIL midrst_out: got busy=%b enable=%b op=%0d want 0/0/0", busy, enable, op); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_epochs;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({epoch_left, 28'd0, op} !== {32'd3, 32'd1}) begin errors++; $display("FAIL ep_start: got epoch=%0d op=%0d want 3/1", epoch_left, op); end
        code_reset = 1'b1;
        tick();
        checks++; if (epoch_left !== 32'd2) begin errors++; $display("FAIL ep_2: got %0d want 2", epoch_left); end
        prog_we = 1'b1; prog_addr = 3'd0; prog_op = 4'hF;
        tick();
        prog_we = 1'b0;
        checks++; if (epoch_left !== 32'd1) begin errors++; $display("FAIL ep_1: got %0d want 1", epoch_left); end
        tick();
        code_reset = 1'b0;
        checks++; if ({done, busy, enable} !== 3'b100) begin errors++; $display("FAIL ep_done: got done/busy/enable=%b want 100", {done, busy, enable}); end
        checks++; if ({epoch_left, 28'd0, op} !== {32'd0, 32'd0}) begin errors++; $display("FAIL ep_done_out: got epoch=%0d op=%0d want 0/0", epoch_left, op); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ep_done_hold: got %b want 1", done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL ep_restart: got busy/done=%b want 10", {busy, done}); end
        checks++; if ({epoch_left, 28'd0, op} !== {32'd3, 32'd1}) begin errors++; $display("FAIL ep_prog_kept: got epoch=%0d op=%0d want 3/1", epoch_left, op); end
    endtask

    task automatic test_start_ignored;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({code_count, epoch_left} !== {32'd2, 32'd3}) begin errors++; $display("FAIL start_in_run: got count=%0d epoch=%0d want 2/3", code_count, epoch_left); end
    endtask

`ifdef SEQ_STALL_EN
    task automatic test_stall;
        tick();
        tick();
        stall = 1'b1; code_reset = 1'b1;
        #1;
        checks++; if ({enable, code_count} !== {1'b0, 32'd4}) begin errors++; $display("FAIL stall_enable: got enable=%b count=%0d want 0/4", enable, code_count); end
        tick();
        tick();
        checks++; if ({code_count, code_index, epoch_left} !== {32'd4, 32'd0, 32'd3}) begin errors++; $display("FAIL stall_hold: got count=%0d index=%0d epoch=%0d want 4/0/3", code_count, code_index, epoch_left); end
        stall = 1'b0; code_reset = 1'b0;
        tick();
        checks++; if ({enable, code_count} !== {1'b1, 32'd5}) begin errors++; $display("FAIL stall_resume: got enable=%b count=%0d want 1/5", enable, code_count); end
    endtask
`endif

    initial begin
        test_reset();
        load_program();
        test_run();
        test_wrap();
        test_priority();
        test_mid_reset();
        test_epochs();
        test_start_ignored();
`ifdef SEQ_STALL_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
